// File: rtl/misaligned_load_unit_if.sv
// Request, response and memory-read signals of the misaligned load unit.
// The load unit connects through master; the core/memory side uses slave.
interface misaligned_load_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_op;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [XLEN-1:0]       resp_data;
  logic                  resp_fault;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_rdata;

  modport master (
    input  req_valid, req_addr, req_op, resp_ready, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_fault, mem_valid, mem_addr
  );

  modport slave (
    output req_valid, req_addr, req_op, resp_ready, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_fault, mem_valid, mem_addr
  );
endinterface

// File: rtl/misaligned_load_unit.sv
// Sub-word/word/dword loads from an XLEN-wide aligned memory port; accesses that
// straddle a word boundary are split into two reads or rejected with a fault.
module misaligned_load_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  misaligned_load_unit_if.master bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] { IDLE, RD0, RD1, RESP } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            op_q, op_d;
  logic                  fault_q, fault_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic [XLEN-1:0]       hi_q, hi_d;

  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [XLEN-1:0]       win;
  logic [XLEN-1:0]       ext_b, ext_h, ext_w;
  logic [XLEN-1:0]       result;
  logic                  sgn;

  // True when the bytes [off, off+size) run past the end of one memory word.
  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [1:0] sz_log2);
    return (5'(off) + (5'd1 << sz_log2)) > 5'(NB);
  endfunction

  always_comb begin
    req_fault = 1'b0;
    if (bus.req_op == 3'b111)
      req_fault = 1'b1;
    if (XLEN == 32 && (bus.req_op == 3'b011 || bus.req_op == 3'b110))
      req_fault = 1'b1;
    if (ALLOW_MISALIGNED == 0 && crosses(bus.req_addr[OFFW-1:0], bus.req_op[1:0]))
      req_fault = 1'b1;
  end

  assign base_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

  // hi_q stays zero unless a second read happened, so the shift is safe either way.
  assign win   = XLEN'({hi_q, lo_q} >> {addr_q[OFFW-1:0], 3'b000});
  assign sgn   = ~op_q[2];
  assign ext_b = {{(XLEN-8){sgn & win[7]}}, win[7:0]};
  assign ext_h = {{(XLEN-16){sgn & win[15]}}, win[15:0]};

  generate
    if (XLEN == 64) begin : g_word_ext
      assign ext_w = {{(XLEN-32){sgn & win[31]}}, win[31:0]};
    end else begin : g_word_full
      assign ext_w = win;
    end
  endgenerate

  always_comb begin
    result = win;
    case (op_q[1:0])
      2'b00:   result = ext_b;
      2'b01:   result = ext_h;
      2'b10:   result = ext_w;
      default: result = win;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    fault_d = fault_q;
    lo_d    = lo_q;
    hi_d    = hi_q;

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_fault = 1'b0;
    bus.resp_data  = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_addr   = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          op_d    = bus.req_op;
          fault_d = req_fault;
          lo_d    = '0;
          hi_d    = '0;
          state_d = req_fault ? RESP : RD0;
        end
      end
      RD0: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = base_addr;
        if (bus.mem_ready) begin
          lo_d    = bus.mem_rdata;
          state_d = crosses(addr_q[OFFW-1:0], op_q[1:0]) ? RD1 : RESP;
        end
      end
      RD1: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = base_addr + ADDR_WIDTH'(NB);
        if (bus.mem_ready) begin
          hi_d    = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        bus.resp_data  = fault_q ? '0 : result;
        if (bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      fault_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      fault_q <= fault_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: tb/tb_misaligned_load_unit.sv
// Bench for misaligned_load_unit: three configurations (32/split, 32/fault, 64/split)
// checked against a byte-level memory model of what each load must return.
module tb_misaligned_load_unit;
  logic        clk;
  logic        resetn;
  int          sel;
  logic        req_valid_t;
  logic [31:0] req_addr_t;
  logic [2:0]  req_op_t;
  logic        resp_ready_t;
  logic        mem_ready_t;
  int          cyc;
  int          vectors;
  int          miscompares;
  bit          chk_en;

  logic        exp_fault;
  logic [63:0] exp_data;
  logic [31:0] acc_q[$];
  logic [7:0]  mem [logic [31:0]];

  logic        obs_req_ready, obs_resp_valid, obs_resp_fault, obs_mem_valid;
  logic [63:0] obs_resp_data;
  logic [31:0] obs_mem_addr;

  misaligned_load_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) bus0();
  misaligned_load_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) bus1();
  misaligned_load_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) bus2();

  misaligned_load_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1)) u_split32 (
    .clk(clk), .resetn(resetn), .bus(bus0.master));
  misaligned_load_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(0)) u_fault32 (
    .clk(clk), .resetn(resetn), .bus(bus1.master));
  misaligned_load_unit #(.XLEN(64), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1)) u_split64 (
    .clk(clk), .resetn(resetn), .bus(bus2.master));

  assign bus0.req_valid  = req_valid_t && (sel == 0);
  assign bus1.req_valid  = req_valid_t && (sel == 1);
  assign bus2.req_valid  = req_valid_t && (sel == 2);
  assign bus0.req_addr   = req_addr_t;
  assign bus1.req_addr   = req_addr_t;
  assign bus2.req_addr   = req_addr_t;
  assign bus0.req_op     = req_op_t;
  assign bus1.req_op     = req_op_t;
  assign bus2.req_op     = req_op_t;
  assign bus0.resp_ready = resp_ready_t && (sel == 0);
  assign bus1.resp_ready = resp_ready_t && (sel == 1);
  assign bus2.resp_ready = resp_ready_t && (sel == 2);
  assign bus0.mem_ready  = mem_ready_t;
  assign bus1.mem_ready  = mem_ready_t;
  assign bus2.mem_ready  = mem_ready_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    obs_req_ready  = bus0.req_ready;
    obs_resp_valid = bus0.resp_valid;
    obs_resp_fault = bus0.resp_fault;
    obs_resp_data  = {32'b0, bus0.resp_data};
    obs_mem_valid  = bus0.mem_valid;
    obs_mem_addr   = bus0.mem_addr;
    case (sel)
      1: begin
        obs_req_ready  = bus1.req_ready;
        obs_resp_valid = bus1.resp_valid;
        obs_resp_fault = bus1.resp_fault;
        obs_resp_data  = {32'b0, bus1.resp_data};
        obs_mem_valid  = bus1.mem_valid;
        obs_mem_addr   = bus1.mem_addr;
      end
      2: begin
        obs_req_ready  = bus2.req_ready;
        obs_resp_valid = bus2.resp_valid;
        obs_resp_fault = bus2.resp_fault;
        obs_resp_data  = bus2.resp_data;
        obs_mem_valid  = bus2.mem_valid;
        obs_mem_addr   = bus2.mem_addr;
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [63:0] rd(input logic [31:0] a, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
    return v;
  endfunction

  task automatic write_bytes(input logic [31:0] a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = v[8*i +: 8];
  endtask

  // Memory answers combinationally from the address presented since the last rising edge.
  initial begin
    bus0.mem_rdata = '0;
    bus1.mem_rdata = '0;
    bus2.mem_rdata = '0;
  end
  always @(negedge clk) begin
    bus0.mem_rdata = 32'(rd(bus0.mem_addr, 4));
    bus1.mem_rdata = 32'(rd(bus1.mem_addr, 4));
    bus2.mem_rdata = rd(bus2.mem_addr, 8);
  end

  function automatic int cfg_xlen(input int s);
    return (s == 2) ? 64 : 32;
  endfunction

  function automatic bit cfg_am(input int s);
    return s != 1;
  endfunction

  // Load semantics straight from byte memory: gather size bytes little-endian, extend.
  task automatic model(input int xl, input bit am, input logic [31:0] a, input logic [2:0] op,
                       output bit f, output logic [63:0] d, output int nacc,
                       output logic [31:0] a0, output logic [31:0] a1);
    int nb, sz, off;
    logic [63:0] v;
    nb  = xl / 8;
    sz  = 1 << op[1:0];
    off = int'(a % 32'(nb));
    f   = (op == 3'b111) || (xl == 32 && (op == 3'b011 || op == 3'b110)) || (!am && off + sz > nb);
    d    = '0;
    nacc = 0;
    a0   = a - 32'(off);
    a1   = a0 + 32'(nb);
    if (!f) begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
      if (!op[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
      if (xl == 32) v = v & 64'hFFFF_FFFF;
      d    = v;
      nacc = (off + sz > nb) ? 2 : 1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%h want=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && chk_en) begin
      if (obs_resp_valid) begin
        check("resp_fault", {63'b0, obs_resp_fault}, {63'b0, exp_fault});
        check("resp_data", obs_resp_data, exp_data);
      end
      if (obs_mem_valid && mem_ready_t)
        check("mem_addr", {32'b0, obs_mem_addr},
              (acc_q.size() > 0) ? {32'b0, acc_q.pop_front()} : 64'hFFFF_FFFF_FFFF_FFFF);
    end
  end

  task automatic do_load(input int s, input logic [31:0] a, input logic [2:0] op, input int stall,
                         input bit use_lit, input logic [63:0] lit_data, input int lit_lat,
                         input string tag);
    bit f;
    logic [63:0] d;
    int n, c0, lat, w;
    logic [31:0] a0, a1;
    @(negedge clk);
    sel = s;
    model(cfg_xlen(s), cfg_am(s), a, op, f, d, n, a0, a1);
    exp_fault = f;
    exp_data  = d;
    if (n >= 1) acc_q.push_back(a0);
    if (n == 2) acc_q.push_back(a1);
    req_addr_t  = a;
    req_op_t    = op;
    req_valid_t = 1'b1;
    w = 0;
    while (!obs_req_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, "_accept"}, {63'b0, obs_req_ready}, 64'd1);
    c0 = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid_t = 1'b0;
    check({tag, "_mem_valid_t1"}, {63'b0, obs_mem_valid}, {63'b0, (n > 0)});
    w = 0;
    while (!obs_resp_valid && w < 20) begin @(negedge clk); w++; end
    check({tag, "_resp_seen"}, {63'b0, obs_resp_valid}, 64'd1);
    lat = cyc - c0;
    check({tag, "_latency"}, 64'(lat), 64'(n + 1));
    if (use_lit) begin
      check({tag, "_lit_data"}, obs_resp_data, lit_data);
      check({tag, "_lit_latency"}, 64'(lat), 64'(lit_lat));
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_req_ready"}, {63'b0, obs_req_ready}, 64'd0);
      check({tag, "_stall_valid"}, {63'b0, obs_resp_valid}, 64'd1);
      check({tag, "_stall_data"}, obs_resp_data, exp_data);
    end
    resp_ready_t = 1'b1;
    @(negedge clk);
    resp_ready_t = 1'b0;
    check({tag, "_done_valid"}, {63'b0, obs_resp_valid}, 64'd0);
    check({tag, "_done_ready"}, {63'b0, obs_req_ready}, 64'd1);
    check({tag, "_acc_left"}, 64'(acc_q.size()), 64'd0);
    acc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mf;
    logic [63:0] md;
    int          mn;
    logic [31:0] ma0, ma1;

    vectors = 0; miscompares = 0; cyc = 0; chk_en = 0; sel = 0;
    req_valid_t = 0; req_addr_t = '0; req_op_t = '0; resp_ready_t = 0; mem_ready_t = 1;
    exp_fault = 0; exp_data = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_mem_valid", {63'b0, obs_mem_valid}, 64'd0);
      check("rst_mem_addr", {32'b0, obs_mem_addr}, 64'd0);
      check("rst_resp_valid", {63'b0, obs_resp_valid}, 64'd0);
      check("rst_resp_data", obs_resp_data, 64'd0);
      check("rst_resp_fault", {63'b0, obs_resp_fault}, 64'd0);
      check("rst_req_ready", {63'b0, obs_req_ready}, 64'd1);
    end
    sel = 0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    chk_en = 1;

    write_bytes(32'h1000, 64'h80FF1234, 4);
    do_load(0, 32'h1003, 3'b000, 0, 1, 64'hFFFF_FF80, 2, "lb_1003");
    do_load(0, 32'h1003, 3'b100, 0, 1, 64'h0000_0080, 2, "lbu_1003");
    do_load(0, 32'h1002, 3'b001, 3, 1, 64'hFFFF_80FF, 2, "lh_stall");

    write_bytes(32'h1000, 64'hAABBCCDD, 4);
    write_bytes(32'h1004, 64'h11223344, 4);
    do_load(0, 32'h1003, 3'b101, 0, 1, 64'h0000_44AA, 3, "lhu_split");
    do_load(1, 32'h1002, 3'b010, 0, 1, 64'h0, 1, "lw_nosplit_fault");
    do_load(0, 32'h1000, 3'b011, 0, 1, 64'h0, 1, "ld_x32_fault");
    do_load(1, 32'h1004, 3'b110, 0, 1, 64'h0, 1, "lwu_x32_fault");
    do_load(2, 32'h1000, 3'b111, 0, 1, 64'h0, 1, "op7_fault");
    do_load(1, 32'h1004, 3'b010, 0, 1, 64'h1122_3344, 2, "lw_aligned");
    do_load(0, 32'h1002, 3'b010, 0, 1, 64'h3344_AABB, 3, "lw_split");
    do_load(2, 32'h1003, 3'b011, 0, 0, 64'h0, 0, "ld_x64_split");

    write_bytes(32'hFFFF_FFFC, 64'h5566AABB, 4);
    write_bytes(32'h0000_0000, 64'h77889900, 4);
    do_load(0, 32'hFFFF_FFFE, 3'b010, 0, 1, 64'h9900_5566, 3, "lw_wrap");

    // Reset while the second read of a split load is stalled.
    @(negedge clk);
    sel = 0;
    mem_ready_t = 1'b1;
    model(32, 1'b1, 32'h1002, 3'b010, mf, md, mn, ma0, ma1);
    exp_fault = mf;
    exp_data  = md;
    acc_q.push_back(ma0);
    req_addr_t = 32'h1002; req_op_t = 3'b010; req_valid_t = 1'b1;
    check("rst_mid_accept", {63'b0, obs_req_ready}, 64'd1);
    @(posedge clk); #1 req_valid_t = 1'b0;
    @(posedge clk); #1 mem_ready_t = 1'b0;
    @(negedge clk);
    check("rst_mid_rd1_valid", {63'b0, obs_mem_valid}, 64'd1);
    check("rst_mid_rd1_addr", {32'b0, obs_mem_addr}, 64'h1004);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_mem_valid", {63'b0, obs_mem_valid}, 64'd0);
    check("rst_mid_mem_addr", {32'b0, obs_mem_addr}, 64'd0);
    check("rst_mid_resp_valid", {63'b0, obs_resp_valid}, 64'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    mem_ready_t = 1'b1;
    acc_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_post_req_ready", {63'b0, obs_req_ready}, 64'd1);
      check("rst_post_resp_valid", {63'b0, obs_resp_valid}, 64'd0);
      check("rst_post_mem_valid", {63'b0, obs_mem_valid}, 64'd0);
    end

    write_bytes(32'h0000_0000, 64'h8000_0000_0000_0000, 8);
    do_load(2, 32'h4, 3'b110, 0, 1, 64'h0000_0000_8000_0000, 2, "lwu_x64");
    do_load(2, 32'h4, 3'b010, 0, 1, 64'hFFFF_FFFF_8000_0000, 2, "lw_x64");
    do_load(2, 32'h7, 3'b000, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 2, "lb_x64");
    do_load(2, 32'h7, 3'b001, 1, 0, 64'h0, 0, "lh_x64_split");

    for (int k = 0; k < 24; k++)
      do_load(int'($urandom_range(0, 2)), 32'h1000 + 32'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 0, 64'h0, 0, "rnd");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/misaligned_load_unit.md
MISALIGNED_LOAD_UNIT -- requirements
Module: misaligned_load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter ALLOW_MISALIGNED, default 1; 1 = split boundary-crossing loads into two accesses, 0 = fault them.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  load request present.
REQ-007 SHALL have port req_ready  output  1  unit can accept a request.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_op  input  3  load op: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110; 111 is illegal.
REQ-010 SHALL have port resp_valid  output  1  result present.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port resp_data  output  XLEN  extended load result.
REQ-013 SHALL have port resp_fault  output  1  request rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_valid  output  1  memory read request.
REQ-015 SHALL have port mem_ready  input  1  memory read done; mem_rdata valid in the same cycle.
REQ-016 SHALL have port mem_addr  output  ADDR_WIDTH  read address, aligned to XLEN/8.
REQ-017 SHALL have port mem_rdata  input  XLEN  read data.

Function
REQ-018 SHALL implement the FSM states IDLE, RD0, RD1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL register addr and op on req_valid&&req_ready; size = 1/2/4/8 bytes by op[1:0]; offset = addr mod (XLEN/8).
REQ-020 SHALL declare fault when op=111, when XLEN=32 and op is LD or LWU, or when ALLOW_MISALIGNED=0 and offset+size > XLEN/8.
REQ-021 SHALL go IDLE->RESP on a faulting request with resp_fault=1 and resp_data=0, and SHALL issue no memory access.
REQ-022 SHALL go IDLE->RD0 on a non-faulting request.
REQ-023 SHALL, in RD0, drive mem_valid=1 and mem_addr=addr with low bits cleared, holding both until mem_ready.
REQ-024 SHALL, on mem_ready in RD0, capture the low word, then go to RD1 if offset+size > XLEN/8, else to RESP.
REQ-025 SHALL, in RD1, drive mem_valid=1 and mem_addr = RD0 address + XLEN/8, modulo 2^ADDR_WIDTH, and capture the high word on mem_ready before going to RESP.
REQ-026 SHALL form resp_data as ({high,low} >> 8*offset), truncated to size bytes, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN; LD SHALL pass through unextended. High is 0 when no RD1 occurred.
REQ-027 SHALL hold resp_valid, resp_data and resp_fault stable in RESP until resp_ready, then go to IDLE; a new request SHALL NOT be accepted in the same cycle.
REQ-028 SHALL have a latency, with mem_ready held high, of: accept at T, mem_valid at T+1, resp_valid at T+2 for a single access, T+3 for a split access, T+1 for a fault.
REQ-029 SHALL deassert mem_valid in every state other than RD0 and RD1.

Reset
REQ-030 SHALL, while resetn=0, force state=IDLE, mem_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0 and captured words=0, immediately and independent of clk.
REQ-031 SHALL abandon any in-flight request on reset mid-operation and produce no response for it; req_ready SHALL be 1 on the first edge after release.

Verification
REQ-032 SHALL be verified (XLEN=32) with: LB @0x1003, word@0x1000=0x80FF1234 -> one access at 0x1000, resp_data=0xFFFFFF80, fault=0.
REQ-033 SHALL be verified with: LHU @0x1003, ALLOW_MISALIGNED=1, word@0x1000=0xAABBCCDD, word@0x1004=0x11223344 -> accesses at 0x1000 then 0x1004, resp_data=0x000044AA.
REQ-034 SHALL be verified with: LW @0x1002, ALLOW_MISALIGNED=0 -> resp_valid at T+1, resp_fault=1, resp_data=0, mem_valid never 1; LD with XLEN=32 -> same.
REQ-035 SHALL be verified with: LW @0xFFFFFFFE, ALLOW_MISALIGNED=1, word@0xFFFFFFFC=0x5566AABB, word@0x0=0x77889900 -> second access at 0x00000000, resp_data=0x99005566.
REQ-036 SHALL be verified with: resp_ready low for 3 cycles in RESP -> resp_valid/resp_data stable and req_ready=0 throughout; the response is accepted on the cycle resp_ready rises.
REQ-037 SHALL be verified with: resetn pulsed low in RD1 while mem_ready=0 -> mem_valid=0 asynchronously, no resp_valid, req_ready=1 after release; XLEN=64 LWU @0x4, dword=0x80000000_00000000 -> resp_data=0x0000000080000000.
